sipo_word_framer: RTL and testbench
===================================

Name: sipo_word_framer

Overview:
- Serial-in, parallel-out framer that sits directly upstream of the 32-bit load register.
- Collects a framed serial bit stream into a WIDTH-bit word.
- On frame completion, presents the word on word_out with a one-cycle load pulse, wired straight to the register's D/load inputs.
- Provides framing control (start/abort), bit-order selection and error flagging.

Parameters:
- WIDTH, 32, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1: first serial bit lands in word_out[WIDTH-1]; 0: first serial bit lands in word_out[0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  frame start strobe; arms or re-arms the framer.
- sin  input  1  serial data bit; sampled only when sin_valid=1.
- sin_valid  input  1  sin carries a valid bit this cycle.
- word_out  output  WIDTH  last completed word; held until the next completion.
- load  output  1  one-cycle pulse, high in the cycle word_out first shows a new word.
- busy  output  1  high while in SHIFT state.
- bit_cnt  output  $clog2(WIDTH+1)  bits accepted in the current frame.
- frame_err  output  1  one-cycle pulse when an in-progress frame is aborted by start.

Behaviour:
- Reset (res=1 at a clock edge, overrides all other inputs):
  - state=IDLE; word_out=0; load=0; busy=0; bit_cnt=0; frame_err=0.
  - Internal shift register is cleared to 0.
  - Reset mid-frame discards the partial word with no load and no frame_err.
- States: IDLE, SHIFT.
- IDLE:
  - sin_valid is ignored.
  - start=1 -> SHIFT next cycle; bit_cnt=0; shift register cleared.
- SHIFT:
  - busy=1.
  - Each cycle with sin_valid=1 and start=0:
    - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
    - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
    - bit_cnt increments by 1.
  - sin_valid=0: shreg and bit_cnt hold; no timeout.
- Completion: in SHIFT with bit_cnt==WIDTH-1, sin_valid=1 and start=0, at that edge:
  - word_out <= completed word, including the final bit;
  - load <= 1;
  - state -> IDLE;
  - bit_cnt <= 0.
- Latency: load and the new word_out are visible the cycle after the last bit is sampled.
- load is high for exactly one cycle; word_out does not change at any other time.
- Abort: start=1 while in SHIFT with bit_cnt>0:
  - frame_err=1 for the next cycle only;
  - shreg cleared; bit_cnt=0; stay in SHIFT.
  - The bit on sin that cycle is discarded.
- start=1 in SHIFT with bit_cnt==0: harmless re-arm; no frame_err.
- Simultaneous start and last bit: start wins. The frame is aborted (frame_err pulse, no load) and the framer re-arms.
- Back-to-back frames:
  - start may be asserted in the same cycle load is high (state is IDLE then).
  - Minimum frame period is WIDTH+1 cycles (one start cycle plus WIDTH bit cycles).
- bit_cnt never exceeds WIDTH-1 while visible.
- load and frame_err are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive res=1 for 2 cycles with start=1, sin_valid=1 -> word_out=0, load=0, busy=0, bit_cnt=0, frame_err=0.
- MSB_FIRST=1 basic frame:
  - start, then 32 consecutive valid bits of 0xDEADBEEF, MSB first.
  - Expect busy=1 throughout the frame.
  - One cycle after the 32nd bit: load=1 for one cycle, word_out=0xDEADBEEF, busy=0.
- MSB_FIRST=0 with gaps:
  - Serialize 0x12345678 LSB first, with sin_valid=0 inserted after bits 3, 15 and 30.
  - Expect word_out=0x12345678 and load=1 exactly once.
  - bit_cnt must hold during each gap.
- Abort:
  - start, 10 valid bits, start again, then 32 bits of 0xA5A5A5A5.
  - Expect frame_err=1 for one cycle and no load for the aborted frame.
  - Then load=1 with word_out=0xA5A5A5A5.
- Start on the last bit:
  - start, 31 valid bits, then the 32nd bit with start=1 in the same cycle.
  - Expect no load, frame_err=1, bit_cnt=0, busy=1, and word_out unchanged from its prior value.
- Back-to-back and mid-frame reset:
  - Two frames 0x00000001 and 0xFFFFFFFF, with the second start in the load cycle -> two load pulses 33 cycles apart, correct words.
  - Then res=1 after 16 bits of a third frame -> word_out=0, no load, no frame_err.

Source files
------------

// File: rtl/sipo_word_framer.sv
// sipo_word_framer
//   Serial-in, parallel-out framer feeding a WIDTH-bit load register.
//   A start strobe arms the framer; WIDTH valid serial bits are collected and
//   the finished word is presented on word_out together with a one-cycle load
//   pulse. start during a partially collected frame aborts it (frame_err).
//
// Ports
//   clk        system clock, rising edge
//   res        synchronous active-high reset
//   start      arm / re-arm strobe
//   sin        serial data bit
//   sin_valid  sin carries a bit this cycle
//   word_out   last completed word, held until the next completion
//   load       one-cycle pulse with each new word_out
//   busy       high while in SHIFT
//   bit_cnt    bits accepted in the current frame
//   frame_err  one-cycle pulse when a partial frame is aborted
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; serial input ignored
//   S_SHIFT | collecting bits; start here re-arms (abort if bits already taken)

module sipo_word_framer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       start,
  input  logic                       sin,
  input  logic                       sin_valid,
  output logic [WIDTH-1:0]           word_out,
  output logic                       load,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       frame_err
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_load;
  logic             r_frame_err;

  state_t           w_state;
  logic [WIDTH-1:0] w_shreg;
  logic [CW-1:0]    w_bit_cnt;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_frame_err;
  logic [WIDTH-1:0] w_shifted;

  // Shift direction decides where the first bit ends up once WIDTH bits are in.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], sin}
                               : {sin, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word      <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shreg     <= w_shreg;
      r_bit_cnt   <= w_bit_cnt;
      r_word      <= w_word;
      r_load      <= w_load;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_shreg     = r_shreg;
    w_bit_cnt   = r_bit_cnt;
    w_word      = r_word;
    w_load      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state   = S_SHIFT;
          w_shreg   = '0;
          w_bit_cnt = '0;
        end
      end
      S_SHIFT: begin
        // start has priority over the incoming bit, including the final one.
        if (start) begin
          w_frame_err = (r_bit_cnt != '0);
          w_shreg     = '0;
          w_bit_cnt   = '0;
        end else if (sin_valid) begin
          if (r_bit_cnt == LAST_IDX) begin
            w_word    = w_shifted;
            w_load    = 1'b1;
            w_state   = S_IDLE;
            w_shreg   = '0;
            w_bit_cnt = '0;
          end else begin
            w_shreg   = w_shifted;
            w_bit_cnt = r_bit_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_shreg   = '0;
        w_bit_cnt = '0;
      end
    endcase
  end

  assign word_out  = r_word;
  assign load      = r_load;
  assign busy      = (r_state == S_SHIFT);
  assign bit_cnt   = r_bit_cnt;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_sipo_word_framer.sv
// Directed bench for sipo_word_framer: one MSB-first and one LSB-first
// instance share the same stimulus; each scenario checks the instance whose
// bit order it targets.

module tb_sipo_word_framer;

  localparam int W  = 32;
  localparam int CW = $clog2(W+1);

  logic          clk;
  logic          res;
  logic          start;
  logic          sin;
  logic          sin_valid;

  logic [W-1:0]  word_m, word_l;
  logic          load_m, load_l;
  logic          busy_m, busy_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic          ferr_m, ferr_l;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sipo_word_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .res(res), .start(start), .sin(sin), .sin_valid(sin_valid),
    .word_out(word_m), .load(load_m), .busy(busy_m), .bit_cnt(cnt_m),
    .frame_err(ferr_m)
  );

  sipo_word_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .res(res), .start(start), .sin(sin), .sin_valid(sin_valid),
    .word_out(word_l), .load(load_l), .busy(busy_l), .bit_cnt(cnt_l),
    .frame_err(ferr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, land 1 time unit after it.
  task automatic drive(input logic st, input logic v, input logic b);
    start     = st;
    sin_valid = v;
    sin       = b;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] d;
  int nload;
  int t_first;
  int t_second;

  initial begin
    res = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    #2;

    // Reset overrides active start/sin_valid
    res = 1'b1;
    drive(1, 1, 1);
    drive(1, 1, 1);
    chk_eq("rst_word_m", word_m, 0);
    chk_eq("rst_word_l", word_l, 0);
    chk_eq("rst_load",   load_m, 0);
    chk_eq("rst_busy",   busy_m, 0);
    chk_eq("rst_cnt",    cnt_m, 0);
    chk_eq("rst_ferr",   ferr_m, 0);
    res = 1'b0;

    // MSB-first frame, no gaps
    d = 32'hDEADBEEF;
    drive(1, 0, 0);
    chk_eq("m_busy_start", busy_m, 1);
    chk_eq("m_cnt_start",  cnt_m, 0);
    for (int i = W-1; i >= 1; i--) begin
      drive(0, 1, d[i]);
      chk_eq("m_busy_mid", busy_m, 1);
      chk_eq("m_cnt_mid",  cnt_m, W-i);
      chk_eq("m_load_mid", load_m, 0);
    end
    drive(0, 1, d[0]);
    chk_eq("m_load",   load_m, 1);
    chk_eq("m_word",   word_m, 32'hDEADBEEF);
    chk_eq("m_busy_0", busy_m, 0);
    chk_eq("m_cnt_0",  cnt_m, 0);
    chk_eq("l_load_same_time", load_l, 1);
    drive(0, 0, 0);
    chk_eq("m_load_once", load_m, 0);
    chk_eq("m_word_held", word_m, 32'hDEADBEEF);

    // LSB-first frame with idle gaps after the 3rd, 15th and 30th bit
    d = 32'h12345678;
    nload = 0;
    drive(1, 0, 0);
    for (int i = 0; i < W; i++) begin
      drive(0, 1, d[i]);
      if (load_l) nload++;
      if (i == 2 || i == 14 || i == 29) begin
        drive(0, 0, 1);
        if (load_l) nload++;
        chk_eq("l_gap_hold", cnt_l, i+1);
        chk_eq("l_gap_busy", busy_l, 1);
      end
    end
    chk_eq("l_load", load_l, 1);
    chk_eq("l_word", word_l, 32'h12345678);
    drive(0, 0, 0);
    if (load_l) nload++;
    chk_eq("l_load_count", nload, 1);

    // Abort after 10 bits, then a full frame
    drive(1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 1);
    chk_eq("ab_cnt_pre", cnt_m, 10);
    drive(1, 1, 1);
    chk_eq("ab_ferr",  ferr_m, 1);
    chk_eq("ab_load",  load_m, 0);
    chk_eq("ab_cnt",   cnt_m, 0);
    chk_eq("ab_busy",  busy_m, 1);
    d = 32'hA5A5A5A5;
    nload = 0;
    for (int i = W-1; i >= 0; i--) begin
      drive(0, 1, d[i]);
      if (i == W-1) chk_eq("ab_ferr_pulse", ferr_m, 0);
      if (i != 0 && load_m) nload++;
    end
    chk_eq("ab_noload_aborted", nload, 0);
    chk_eq("ab_load_new",  load_m, 1);
    chk_eq("ab_word_m",    word_m, 32'hA5A5A5A5);
    chk_eq("ab_word_l",    word_l, 32'hA5A5A5A5);
    chk_eq("ab_ferr_load", ferr_m, 0);

    // start coincides with the 32nd bit: abort wins
    drive(1, 0, 0);
    for (int i = 0; i < W-1; i++) drive(0, 1, 1);
    drive(1, 1, 1);
    chk_eq("lb_load", load_m, 0);
    chk_eq("lb_ferr", ferr_m, 1);
    chk_eq("lb_cnt",  cnt_m, 0);
    chk_eq("lb_busy", busy_m, 1);
    chk_eq("lb_word", word_m, 32'hA5A5A5A5);

    // Back-to-back frames; first start is a harmless re-arm at bit_cnt=0
    d = 32'h00000001;
    drive(1, 0, 0);
    chk_eq("rearm_ferr", ferr_m, 0);
    chk_eq("rearm_busy", busy_m, 1);
    for (int i = W-1; i >= 0; i--) drive(0, 1, d[i]);
    chk_eq("bb1_load",   load_m, 1);
    chk_eq("bb1_word_m", word_m, 32'h00000001);
    chk_eq("bb1_word_l", word_l, 32'h80000000);
    t_first = cyc;
    drive(1, 0, 0);
    chk_eq("bb2_busy", busy_m, 1);
    t_second = -1;
    for (int i = 0; i < W; i++) begin
      drive(0, 1, 1);
      if (load_m && t_second < 0) t_second = cyc;
    end
    chk_eq("bb2_load",   load_m, 1);
    chk_eq("bb2_word_m", word_m, 32'hFFFFFFFF);
    chk_eq("bb2_word_l", word_l, 32'hFFFFFFFF);
    chk_eq("bb_spacing", t_second - t_first, 33);

    // Mid-frame reset after 16 bits
    drive(1, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 1);
    chk_eq("mr_cnt_pre", cnt_m, 16);
    res = 1'b1;
    drive(0, 1, 1);
    res = 1'b0;
    chk_eq("mr_word", word_m, 0);
    chk_eq("mr_load", load_m, 0);
    chk_eq("mr_ferr", ferr_m, 0);
    chk_eq("mr_busy", busy_m, 0);
    chk_eq("mr_cnt",  cnt_m, 0);
    drive(0, 1, 1);
    chk_eq("mr_load_after", load_m, 0);
    chk_eq("mr_busy_after", busy_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
